seq_add_sub: RTL

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

---
 rtl/seq_add_sub.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_add_sub.sv
// Chunk-serial two's-complement adder/subtractor: CHUNK bits per clock, LSB
// chunk first, with a registered result, carry-out and signed overflow flag.
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int N = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aOp_q, aOp_d;
  logic [WIDTH-1:0] bOp_q, bOp_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  int               chunkShift;
  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK:0]   chunkSum;
  logic [WIDTH-1:0] workMerged;
  logic             msbCarryIn;
  logic             lastChunk;

  // Datapath for the chunk selected by idx_q; bOp_q already holds ~b for subtract.
  always_comb begin
    chunkShift = int'(idx_q) * CHUNK;
    aChunk     = CHUNK'(aOp_q >> chunkShift);
    bChunk     = CHUNK'(bOp_q >> chunkShift);
    chunkSum   = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry_q};
    workMerged = (work_q & ~(CHUNK_MASK << chunkShift)) |
                 (WIDTH'(chunkSum[CHUNK-1:0]) << chunkShift);
    // Sum bit = a ^ b ^ carry-in, so the MSB carry-in can be recovered from the result.
    msbCarryIn = aOp_q[WIDTH-1] ^ bOp_q[WIDTH-1] ^ workMerged[WIDTH-1];
    lastChunk  = (idx_q == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    aOp_d   = aOp_q;
    bOp_d   = bOp_q;
    work_d  = work_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aOp_d   = a;
          bOp_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d  = workMerged;
        carry_d = chunkSum[CHUNK];
        if (lastChunk) begin
          idx_d   = '0;
          s_d     = workMerged;
          c_d     = chunkSum[CHUNK];
          ovf_d   = msbCarryIn ^ chunkSum[CHUNK];
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aOp_q   <= '0;
      bOp_q   <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aOp_q   <= aOp_d;
      bOp_q   <= bOp_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign s     = s_q;
  assign c     = c_q;
  assign ovf   = ovf_q;

endmodule
